data_memory_loader: RTL and testbench
=====================================

DATA_MEMORY_LOADER -- requirements
Module: data_memory_loader

Interface
REQ-001 SHALL have parameter LOAD_WORDS, default 8'd18, number of 16-bit words loaded to data memory, legal range 1..255.
REQ-002 SHALL have parameter RESULT_BASE, default 8'd18, first data-memory address read back after processing.
REQ-003 SHALL have parameter RESULT_WORDS, default 8'd9, number of result words read back, legal range 1..255.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_data  input  8  inbound byte stream.
REQ-007 SHALL have port rx_valid  input  1  rx_data is valid.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both high.
REQ-009 SHALL have port mem_write_en  output  1  data-memory write strobe.
REQ-010 SHALL have port mem_addr  output  8  data-memory address.
REQ-011 SHALL have port mem_datain  output  16  data-memory write data.
REQ-012 SHALL have port mem_dataout  input  16  data-memory read data, valid one clock after the address is applied.
REQ-013 SHALL have port mem_owner  output  1  high when the loader drives the memory port (external mux select).
REQ-014 SHALL have port status  output  2  core control: 2'b00 load, 2'b01 run, 2'b10 done.
REQ-015 SHALL have port end_process  input  1  core completion, level-sensitive.
REQ-016 SHALL have ports tx_data (output, 8), tx_valid (output, 1), tx_ready (input, 1): outbound byte stream, valid/ready handshake.

Function
REQ-017 SHALL implement states LOAD, RUN, RD_REQ, RD_DATA, TX_HI, TX_LO, FINISH.
REQ-018 LOAD SHALL assert rx_ready and accept bytes high byte first; each accepted high/low byte pair forms one word {hi,lo}.
REQ-019 SHALL pulse mem_write_en for exactly one cycle, the cycle after the low-byte handshake, with mem_addr = word index (0..LOAD_WORDS-1) and mem_datain = {hi,lo}.
REQ-020 SHALL deassert rx_ready during the write cycle, so at most one byte is accepted every cycle and no byte is lost.
REQ-021 Gaps in rx_valid SHALL stall the load without corrupting the partial word.
REQ-022 After the write of word LOAD_WORDS-1, SHALL enter RUN on the next cycle with status=2'b01 and mem_owner=0.
REQ-023 RUN SHALL leave to RD_REQ on the first cycle end_process is high; end_process SHALL be ignored in every other state.
REQ-024 RD_REQ SHALL drive mem_owner=1 and mem_addr=RESULT_BASE+k with mem_write_en=0; RD_DATA SHALL capture mem_dataout one cycle later.
REQ-025 TX_HI SHALL present tx_data=word[15:8] with tx_valid=1; TX_LO SHALL present word[7:0]; each state advances only on tx_ready, with tx_data stable while stalled.
REQ-026 After the TX_LO handshake for word k<RESULT_WORDS-1, SHALL return to RD_REQ for k+1; after the last word, SHALL enter FINISH.
REQ-027 mem_addr SHALL wrap modulo 256 when RESULT_BASE+k exceeds 8'hFF.
REQ-028 FINISH SHALL hold status=2'b10, rx_ready=0 and tx_valid=0, then move to LOAD (word index 0) the cycle after rx_valid is seen high; that byte SHALL NOT be consumed in FINISH.
REQ-029 mem_owner SHALL be 1 in every state except RUN.

Reset
REQ-030 reset_n low SHALL immediately force state LOAD, word/byte counters 0, status=2'b00, mem_write_en=0, mem_addr=0, mem_datain=0, rx_ready=0, tx_valid=0, tx_data=0, mem_owner=1.
REQ-031 rx_ready SHALL first rise on the first clock edge after reset_n deasserts.
REQ-032 Reset asserted mid-load, mid-run or mid-transmit SHALL discard all progress; no write strobe SHALL occur during reset.

Structure
REQ-033 State encodings and STATUS_LOAD/STATUS_RUN/STATUS_DONE constants SHALL live in the shared mm_defs package and be reused by core_0.
REQ-034 Byte-to-word assembly SHALL be a single sub-module byte_word_packer; all other logic SHALL be flat.

Verification
REQ-035 LOAD_WORDS=4; bytes 12 34 AB CD 00 01 FF FF -> writes 0x1234@0, 0xABCD@1, 0x0001@2, 0xFFFF@3, each exactly one cycle; status becomes 2'b01 one cycle after the last write.
REQ-036 Same stream with rx_valid toggled every other cycle -> identical writes; no duplicates or drops.
REQ-037 end_process pulsed during LOAD, then asserted in RUN; memory holds 0x0A0B@RESULT_BASE=8'hFF and 0x0C0D@8'h00 (RESULT_WORDS=2) -> tx bytes 0A 0B 0C 0D with the address wrapping to 0; status becomes 2'b10.
REQ-038 tx_ready held low 5 cycles during TX_HI -> tx_data stable and tx_valid held high; byte order unchanged.
REQ-039 reset_n pulsed low after 3 of 8 load bytes -> no writes, all outputs at reset values; a fresh 8-byte load then starts at address 0.
REQ-040 In FINISH, rx_valid raised with byte 0x55 -> not consumed in FINISH; accepted as the high byte of word 0 in LOAD.

Source files
------------

// File: rtl/mm_defs.sv
// Shared definitions for the data-memory loader and the processing core.
// Holds the loader state encoding and the status codes driven to core_0.
package mm_defs;

  // state      | meaning
  // ST_LOAD    | accept byte pairs and write them to data memory
  // ST_RUN     | core owns memory and runs, wait for end_process
  // ST_RD_REQ  | drive read address RESULT_BASE+k
  // ST_RD_DATA | capture memory read data
  // ST_TX_HI   | send result word high byte
  // ST_TX_LO   | send result word low byte
  // ST_FINISH  | idle until a new inbound byte appears
  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_TX_HI   = 3'd4,
    ST_TX_LO   = 3'd5,
    ST_FINISH  = 3'd6
  } state_t;

  localparam logic [1:0] STATUS_LOAD = 2'b00;
  localparam logic [1:0] STATUS_RUN  = 2'b01;
  localparam logic [1:0] STATUS_DONE = 2'b10;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles inbound bytes (high byte first) into 16-bit words.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   i_clear        : drop any partial word and pending strobe
//   i_fire         : a byte is transferred this cycle
//   i_byte         : the transferred byte
//   o_lo_fire      : the current transfer completes a word
//   o_word         : last completed word {hi,lo}
//   o_word_vld     : one-cycle pulse, the cycle after the low-byte transfer
module byte_word_packer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_fire,
  input  logic [7:0]  i_byte,
  output logic        o_lo_fire,
  output logic [15:0] o_word,
  output logic        o_word_vld
);

  logic       r_phase;
  logic [7:0] r_hi;

  assign o_lo_fire = i_fire & r_phase;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase    <= 1'b0;
      r_hi       <= 8'h00;
      o_word     <= 16'h0000;
      o_word_vld <= 1'b0;
    end else if (i_clear) begin
      r_phase    <= 1'b0;
      o_word_vld <= 1'b0;
    end else begin
      o_word_vld <= o_lo_fire;
      if (i_fire) begin
        r_phase <= ~r_phase;
        if (r_phase) o_word <= {r_hi, i_byte};
        else         r_hi   <= i_byte;
      end
    end
  end

endmodule

// File: rtl/data_memory_loader.sv
// Loads a byte stream into data memory, hands memory to the core, then
// reads RESULT_WORDS results back and streams them out high byte first.
// Ports:
//   clock, reset_n               : clock and async active-low reset
//   rx_data/rx_valid/rx_ready    : inbound byte stream
//   tx_data/tx_valid/tx_ready    : outbound byte stream
//   mem_write_en/mem_addr/
//   mem_datain/mem_dataout       : data-memory port (read latency 1)
//   mem_owner                    : 1 while the loader drives memory
//   status                       : load/run/done indication to the core
//   end_process                  : core completion (level)
module data_memory_loader
  import mm_defs::*;
#(
  parameter logic [7:0] LOAD_WORDS   = 8'd18,
  parameter logic [7:0] RESULT_BASE  = 8'd18,
  parameter logic [7:0] RESULT_WORDS = 8'd9
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_write_en,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_datain,
  input  logic [15:0] mem_dataout,
  output logic        mem_owner,
  output logic [1:0]  status,
  input  logic        end_process,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_rx_ready;
  logic [7:0]  r_word_idx;
  logic [7:0]  r_rd_idx;
  logic [15:0] r_rd_word;
  logic        w_rx_fire;
  logic        w_lo_fire;
  logic        w_word_vld;
  logic [15:0] w_word;
  logic        w_last_load;
  logic        w_last_rd;

  assign w_rx_fire   = rx_valid & r_rx_ready;
  assign w_last_load = (r_word_idx == LOAD_WORDS - 8'd1);
  assign w_last_rd   = (r_rd_idx == RESULT_WORDS - 8'd1);

  byte_word_packer u_packer (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_clear    (r_state == ST_FINISH),
    .i_fire     (w_rx_fire),
    .i_byte     (rx_data),
    .o_lo_fire  (w_lo_fire),
    .o_word     (w_word),
    .o_word_vld (w_word_vld)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD:    if (w_word_vld && w_last_load) w_state_next = ST_RUN;
      ST_RUN:     if (end_process) w_state_next = ST_RD_REQ;
      ST_RD_REQ:  w_state_next = ST_RD_DATA;
      ST_RD_DATA: w_state_next = ST_TX_HI;
      ST_TX_HI:   if (tx_ready) w_state_next = ST_TX_LO;
      ST_TX_LO:   if (tx_ready) w_state_next = w_last_rd ? ST_FINISH : ST_RD_REQ;
      ST_FINISH:  if (rx_valid) w_state_next = ST_LOAD;
      default:    w_state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_LOAD;
      r_rx_ready <= 1'b0;
      r_word_idx <= 8'h00;
      r_rd_idx   <= 8'h00;
      r_rd_word  <= 16'h0000;
    end else begin
      r_state    <= w_state_next;
      // Closed during the write cycle that follows a low byte.
      r_rx_ready <= (w_state_next == ST_LOAD) && !w_lo_fire;
      if (r_state == ST_FINISH)  r_word_idx <= 8'h00;
      else if (w_word_vld)       r_word_idx <= r_word_idx + 8'd1;
      if (r_state == ST_RUN)     r_rd_idx <= 8'h00;
      else if (r_state == ST_TX_LO && tx_ready && !w_last_rd)
                                 r_rd_idx <= r_rd_idx + 8'd1;
      if (r_state == ST_RD_DATA) r_rd_word <= mem_dataout;
    end
  end

  assign rx_ready     = r_rx_ready;
  assign mem_write_en = w_word_vld;
  assign mem_datain   = w_word;
  assign mem_owner    = (r_state != ST_RUN);
  assign tx_valid     = (r_state == ST_TX_HI) || (r_state == ST_TX_LO);

  always_comb begin
    // 8-bit sum wraps past 8'hFF back to 0.
    mem_addr = r_word_idx;
    if (r_state inside {ST_RD_REQ, ST_RD_DATA, ST_TX_HI, ST_TX_LO})
      mem_addr = RESULT_BASE + r_rd_idx;
  end

  always_comb begin
    status = STATUS_DONE;
    if (r_state == ST_LOAD)     status = STATUS_LOAD;
    else if (r_state == ST_RUN) status = STATUS_RUN;
  end

  always_comb begin
    tx_data = 8'h00;
    if (r_state == ST_TX_HI)      tx_data = r_rd_word[15:8];
    else if (r_state == ST_TX_LO) tx_data = r_rd_word[7:0];
  end

endmodule

// File: tb/tb_data_memory_loader.sv
module tb_data_memory_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_write_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_datain;
  logic [15:0] mem_dataout;
  logic        mem_owner;
  logic [1:0]  status;
  logic        end_process = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  logic        core_we = 1'b0;
  logic [7:0]  core_addr = 8'h00;
  logic [15:0] core_din = 16'h0000;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [256];
  logic [7:0]  tx_q [$];
  logic [7:0]  wr_addr_q [$];
  logic [15:0] wr_data_q [$];

  logic [7:0]  stream [8];
  logic [15:0] exp_w [4];

  always #5 clock = ~clock;

  data_memory_loader #(
    .LOAD_WORDS   (8'd4),
    .RESULT_BASE  (8'hFF),
    .RESULT_WORDS (8'd2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_datain   (mem_datain),
    .mem_dataout  (mem_dataout),
    .mem_owner    (mem_owner),
    .status       (status),
    .end_process  (end_process),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  // external mux between loader and core, synchronous memory
  wire        w_we   = mem_owner ? mem_write_en : core_we;
  wire [7:0]  w_addr = mem_owner ? mem_addr : core_addr;
  wire [15:0] w_din  = mem_owner ? mem_datain : core_din;

  always @(posedge clock) begin
    if (w_we) mem[w_addr] <= w_din;
    mem_dataout <= mem[w_addr];
  end

  always @(negedge clock) begin
    if (mem_write_en) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_datain);
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  // called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clock);
      if (rx_ready) done = 1'b1;
      @(posedge clock); #1;
    end
    rx_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rx_handshake: byte %h not accepted, expected acceptance", b);
    end
  endtask

  task automatic core_write(input logic [7:0] a, input logic [15:0] d);
    core_addr = a;
    core_din  = d;
    core_we   = 1'b1;
    @(posedge clock); #1;
    core_we   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL %s status: got %b expected 00", tag, status); end
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL %s mem_write_en: got %b expected 0", tag, mem_write_en); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL %s mem_addr: got %h expected 00", tag, mem_addr); end
    checks++; if (mem_datain !== 16'h0000) begin errors++; $display("FAIL %s mem_datain: got %h expected 0000", tag, mem_datain); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL %s rx_ready: got %b expected 0", tag, rx_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL %s tx_valid: got %b expected 0", tag, tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL %s tx_data: got %h expected 00", tag, tx_data); end
    checks++; if (mem_owner !== 1'b1) begin errors++; $display("FAIL %s mem_owner: got %b expected 1", tag, mem_owner); end
  endtask

  task automatic check_release(input string tag);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL %s rx_ready_early: got %b expected 0", tag, rx_ready); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL %s rx_ready_rise: got %b expected 1", tag, rx_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    check_release("reset");
  endtask

  task automatic check_load_end(input string tag, input int base);
    @(negedge clock);
    checks++; if (mem_write_en !== 1'b1 || mem_addr !== 8'd3 || mem_datain !== 16'hFFFF) begin
      errors++; $display("FAIL %s last_write: got we=%b addr=%h data=%h expected we=1 addr=03 data=FFFF", tag, mem_write_en, mem_addr, mem_datain); end
    checks++; if (rx_ready !== 1'b0 || status !== 2'b00) begin
      errors++; $display("FAIL %s write_cycle: got rx_ready=%b status=%b expected 0/00", tag, rx_ready, status); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (status !== 2'b01 || mem_owner !== 1'b0 || mem_write_en !== 1'b0) begin
      errors++; $display("FAIL %s run_entry: got status=%b owner=%b we=%b expected 01/0/0", tag, status, mem_owner, mem_write_en); end
    checks++; if (wr_addr_q.size() - base !== 4) begin
      errors++; $display("FAIL %s write_count: got %0d expected 4", tag, wr_addr_q.size() - base); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr_q[base+i] !== 8'(i) || wr_data_q[base+i] !== exp_w[i]) begin
        errors++; $display("FAIL %s write_%0d: got %h@%h expected %h@%h", tag, i, wr_data_q[base+i], wr_addr_q[base+i], exp_w[i], 8'(i)); end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_load_basic;
    int base;
    base = wr_addr_q.size();
    for (int i = 0; i < 8; i++) send_byte(stream[i]);
    check_load_end("load_basic", base);
  endtask

  task automatic wait_tx(input int n, input int base, input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (tx_q.size() - base >= n) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL %s tx_timeout: got %0d bytes expected %0d", tag, tx_q.size() - base, n); end
  endtask

  task automatic check_finish(input string tag);
    @(posedge clock); #1;
    repeat (2) begin
      @(negedge clock);
      checks++; if (status !== 2'b10 || rx_ready !== 1'b0 || tx_valid !== 1'b0 || mem_owner !== 1'b1) begin
        errors++; $display("FAIL %s finish: got status=%b rx_ready=%b tx_valid=%b owner=%b expected 10/0/0/1", tag, status, rx_ready, tx_valid, mem_owner); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_readback_wrap;
    logic [7:0] exp_b [4];
    int base;
    exp_b = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    base = tx_q.size();
    core_write(8'hFF, 16'h0A0B);
    core_write(8'h00, 16'h0C0D);
    @(negedge clock);
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL readback run_hold: got %b expected 01", status); end
    @(posedge clock); #1;
    tx_ready = 1'b1;
    end_process = 1'b1;
    @(posedge clock); #1;
    end_process = 1'b0;
    wait_tx(4, base, "readback");
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_q.size() > base + i && tx_q[base+i] !== exp_b[i]) begin
        errors++; $display("FAIL readback byte_%0d: got %h expected %h", i, tx_q[base+i], exp_b[i]); end
    end
    tx_ready = 1'b0;
    check_finish("readback");
  endtask

  task automatic test_finish_byte;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    @(negedge clock);
    checks++; if (rx_ready !== 1'b0 || status !== 2'b10) begin
      errors++; $display("FAIL finish_byte in_finish: got rx_ready=%b status=%b expected 0/10", rx_ready, status); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (rx_ready !== 1'b1 || status !== 2'b00) begin
      errors++; $display("FAIL finish_byte in_load: got rx_ready=%b status=%b expected 1/00", rx_ready, status); end
    @(posedge clock); #1;
    send_byte(8'h66);
    @(negedge clock);
    checks++; if (mem_write_en !== 1'b1 || mem_addr !== 8'h00 || mem_datain !== 16'h5566) begin
      errors++; $display("FAIL finish_byte word0: got we=%b %h@%h expected 1 5566@00", mem_write_en, mem_datain, mem_addr); end
    @(posedge clock); #1;
    send_byte(8'h77);
  endtask

  task automatic test_reset_mid_load;
    int base;
    base = wr_addr_q.size();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) begin
      @(negedge clock);
      checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL mid_reset strobe: got %b expected 0", mem_write_en); end
    end
    check_release("mid_reset");
    checks++; if (wr_addr_q.size() !== base) begin
      errors++; $display("FAIL mid_reset writes: got %0d expected 0", wr_addr_q.size() - base); end
  endtask

  task automatic test_gapped_load;
    int base;
    base = wr_addr_q.size();
    for (int i = 0; i < 8; i++) begin
      send_byte(stream[i]);
      if (i == 7) break;
      if (i == 3) begin
        end_process = 1'b1;
        @(negedge clock);
        checks++; if (status !== 2'b00 || mem_owner !== 1'b1) begin
          errors++; $display("FAIL gapped end_process_ignored: got status=%b owner=%b expected 00/1", status, mem_owner); end
        @(posedge clock); #1;
        end_process = 1'b0;
      end else begin
        @(posedge clock); #1;
      end
    end
    check_load_end("gapped", base);
  endtask

  task automatic test_tx_stall;
    logic [7:0] exp_b [4];
    int base;
    bit seen;
    exp_b = '{8'h5A, 8'hA5, 8'h3C, 8'h96};
    base = tx_q.size();
    seen = 1'b0;
    core_write(8'hFF, 16'h5AA5);
    core_write(8'h00, 16'h3C96);
    tx_ready = 1'b0;
    end_process = 1'b1;
    @(posedge clock); #1;
    end_process = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (tx_valid) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall tx_valid_timeout: got 0 expected 1"); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin
        errors++; $display("FAIL stall hold_%0d: got valid=%b data=%h expected 1/5A", c, tx_valid, tx_data); end
      if (c < 4) @(negedge clock);
    end
    @(posedge clock); #1;
    tx_ready = 1'b1;
    wait_tx(4, base, "stall");
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_q.size() > base + i && tx_q[base+i] !== exp_b[i]) begin
        errors++; $display("FAIL stall byte_%0d: got %h expected %h", i, tx_q[base+i], exp_b[i]); end
    end
    tx_ready = 1'b0;
    check_finish("stall");
  endtask

  initial begin
    stream = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF};
    exp_w  = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
    test_reset();
    test_load_basic();
    test_readback_wrap();
    test_finish_byte();
    test_reset_mid_load();
    test_gapped_load();
    test_tx_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
